// File: rtl/cordic_vector_engine.sv
// Iterative CORDIC vectoring engine.
// Accepts one pre-rotated (x, y, angle) triple and drives y toward zero with
// one shift-add micro-rotation per clock. It returns the raw magnitude, which
// is not gain-compensated (K ~ 1.6468), and the accumulated angle.
// The angle scale is 0x20000000 = 90 degrees, and angles wrap modulo 2^WIDTH.
module cordic_vector_engine #(
    parameter int WIDTH = 32,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [WIDTH-1:0] angle_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] magnitude,
    output logic [WIDTH-1:0] angle_out,
    output logic             busy
);

    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
    // Two growth bits for the CORDIC gain plus one guard/sign bit.
    localparam int XW = WIDTH + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITERATE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        iter_q, iter_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [XW-1:0] x_sh, y_sh, x_rot, y_rot;
    logic [WIDTH-1:0]     z_q, z_d, z_rot, atan_step;
    logic [WIDTH+1:0]     mag_q, mag_d;
    logic [WIDTH-1:0]     ang_q, ang_d;
    logic                 unused_x_msb;

    // atan(2^-i) table, scaled so that 2^32 represents 720 degrees.
    function automatic logic [31:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = 32'h1000_0000;
            5'd1:    atan_lut = 32'h0972_028F;
            5'd2:    atan_lut = 32'h04FD_9C2E;
            5'd3:    atan_lut = 32'h0288_88EA;
            5'd4:    atan_lut = 32'h0145_86A2;
            5'd5:    atan_lut = 32'h00A2_EBF1;
            5'd6:    atan_lut = 32'h0051_7B0F;
            5'd7:    atan_lut = 32'h0028_BE2B;
            5'd8:    atan_lut = 32'h0014_5F2A;
            5'd9:    atan_lut = 32'h000A_2F97;
            5'd10:   atan_lut = 32'h0005_17CC;
            5'd11:   atan_lut = 32'h0002_8BE6;
            5'd12:   atan_lut = 32'h0001_45F3;
            5'd13:   atan_lut = 32'h0000_A2FA;
            5'd14:   atan_lut = 32'h0000_517D;
            5'd15:   atan_lut = 32'h0000_28BE;
            5'd16:   atan_lut = 32'h0000_145F;
            5'd17:   atan_lut = 32'h0000_0A30;
            5'd18:   atan_lut = 32'h0000_0518;
            5'd19:   atan_lut = 32'h0000_028C;
            5'd20:   atan_lut = 32'h0000_0146;
            5'd21:   atan_lut = 32'h0000_00A3;
            5'd22:   atan_lut = 32'h0000_0051;
            5'd23:   atan_lut = 32'h0000_0029;
            5'd24:   atan_lut = 32'h0000_0014;
            5'd25:   atan_lut = 32'h0000_000A;
            5'd26:   atan_lut = 32'h0000_0005;
            5'd27:   atan_lut = 32'h0000_0003;
            5'd28:   atan_lut = 32'h0000_0001;
            5'd29:   atan_lut = 32'h0000_0001;
            default: atan_lut = 32'h0000_0000;
        endcase
    endfunction

    // The table is built for a 32-bit angle word.
    assign atan_step = WIDTH'(atan_lut(5'(iter_q)));

    // Single micro-rotation.
    // The sign of y selects the direction, and all terms use the current register values.
    always_comb begin
        x_sh = x_q >>> iter_q;
        y_sh = y_q >>> iter_q;
        if (y_q[XW-1]) begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - atan_step;
        end else begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + atan_step;
        end
    end

    // The final x is known to be non-negative, so its sign bit is never exported.
    assign unused_x_msb = x_rot[XW-1];

    // Next-state logic and datapath load control.
    // Every register holds its value unless the current state updates it.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        mag_d   = mag_q;
        ang_d   = ang_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_ITERATE;
                    iter_d  = '0;
                    x_d     = {{3{x_in[WIDTH-1]}}, x_in};
                    y_d     = {{3{y_in[WIDTH-1]}}, y_in};
                    z_d     = angle_in;
                end
            end
            S_ITERATE: begin
                x_d = x_rot;
                y_d = y_rot;
                z_d = z_rot;
                if (iter_q == IW'(ITER - 1)) begin
                    state_d = S_DONE;
                    mag_d   = x_rot[WIDTH+1:0];
                    ang_d   = z_rot;
                end else begin
                    iter_d = iter_q + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    // Reset aborts any vector in flight and clears the results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mag_q   <= '0;
            ang_q   <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            mag_q   <= mag_d;
            ang_q   <= ang_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign magnitude = mag_q;
    assign angle_out = ang_q;

endmodule

// File: tb/tb_cordic_vector_engine.sv
// Directed testbench for cordic_vector_engine.
// Expected magnitude and angle come from a real-number model.
// Each accepted vector pushes its expectation to a queue,
// and that entry is popped when the result handshake completes.
module tb_cordic_vector_engine;

    localparam int WIDTH = 32;
    localparam int ITER  = 16;
    localparam real PI   = 3.14159265358979323846;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x_in, y_in, angle_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] magnitude;
    logic [WIDTH-1:0] angle_out;
    logic             busy;

    typedef struct {
        real         mag;
        logic [31:0] ang;
        bit          ang_care;
    } exp_t;

    exp_t sb_q[$];
    int   n_asserts = 0;
    int   n_fails   = 0;
    real  gain;

    always #5 clk = ~clk;

    cordic_vector_engine #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_in  (angle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .magnitude (magnitude),
        .angle_out (angle_out),
        .busy      (busy)
    );

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mag(input string tag, input logic [WIDTH+1:0] obs, input real exp);
        real o;
        real tol;
        o   = real'(obs);
        tol = exp * 1.0e-4 + 4.0;
        n_asserts++;
        assert ((o - exp <= tol) && (exp - o <= tol)) else begin
            n_fails++;
            $error("FAIL %s: observed magnitude %0.1f expected %0.1f +/- %0.1f", tag, o, exp, tol);
        end
    endtask

    task automatic chk_ang(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        logic [31:0] d;
        int          sd;
        d  = obs - exp;
        sd = $signed(d);
        n_asserts++;
        assert ((sd >= -12288) && (sd <= 12288)) else begin
            n_fails++;
            $error("FAIL %s: observed angle 0x%08h expected 0x%08h +/- 0x3000", tag, obs, exp);
        end
    endtask

    // Model of one vector: raw CORDIC magnitude and atan2 plus the quadrant offset.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] a, input bit ang_care);
        exp_t e;
        real  xr;
        real  yr;
        int   at;
        xr         = $itor($signed(x));
        yr         = $itor($signed(y));
        e.mag      = gain * $sqrt(xr * xr + yr * yr);
        at         = $rtoi($atan2(yr, xr) * 1073741824.0 / PI);
        e.ang      = a + 32'(at);
        e.ang_care = ang_care;
        return e;
    endfunction

    // Present a vector at a falling edge and wait (bounded) for acceptance.
    // The task returns on the falling edge after the accepting edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] a, input bit ang_care, input string tag);
        int guard;
        in_valid = 1'b1;
        x_in     = x;
        y_in     = y;
        angle_in = a;
        guard    = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk_eq({tag, "_accept_timeout"}, 64'(in_ready), 64'd1);
        sb_q.push_back(model(x, y, a, ang_care));
        @(negedge clk);
        in_valid = 1'b0;
        $display("send %s: x=0x%08h y=0x%08h a=0x%08h", tag, x, y, a);
    endtask

    // Count falling edges until out_valid is high, with a bound on the wait.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Pop the oldest expectation and compare it with the presented result.
    task automatic check_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk_eq({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk_mag({tag, "_mag"}, magnitude, e.mag);
            if (e.ang_care) chk_ang({tag, "_ang"}, angle_out, e.ang);
            $display("result %s: mag=0x%09h ang=0x%08h", tag, magnitude, angle_out);
        end
    endtask

    // Send one vector, check its latency and result, and complete the output handshake.
    task automatic run_vec(input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] a, input bit ang_care, input string tag);
        int lat;
        send(x, y, a, ang_care, tag);
        wait_out(lat);
        chk_eq({tag, "_latency"}, 64'(lat), 64'(ITER));
        check_out(tag);
        out_ready = 1'b1;
        @(negedge clk);
        chk_eq({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        real p;
        int  lat;
        bit  seen;

        gain = 1.0;
        p    = 1.0;
        for (int i = 0; i < ITER; i++) begin
            gain = gain * $sqrt(1.0 + p);
            p    = p / 4.0;
        end

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x_in      = '0;
        y_in      = '0;
        angle_in  = '0;
        out_ready = 1'b1;
        #2;
        chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
        chk_eq("rst_in_ready",  64'(in_ready),  64'd1);
        chk_eq("rst_busy",      64'(busy),      64'd0);
        chk_eq("rst_magnitude", 64'(magnitude), 64'd0);
        chk_eq("rst_angle",     64'(angle_out), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Main function: on-axis, +45, -45, quadrant offset, zero vector.
        run_vec(32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, "v_axis");
        run_vec(32'h1000_0000, 32'h1000_0000, 32'h0000_0000, 1'b1, "v_p45");
        run_vec(32'h1000_0000, 32'hF000_0000, 32'h0000_0000, 1'b1, "v_m45");
        run_vec(32'h1000_0000, 32'h0000_0000, 32'h2000_0000, 1'b1, "v_offset");
        run_vec(32'h0000_0000, 32'h0000_0000, 32'h4000_0000, 1'b0, "v_zero");

        // Hold the result in DONE while input requests must be ignored.
        out_ready = 1'b0;
        send(32'h3000_0000, 32'h0800_0000, 32'h0000_0000, 1'b1, "v_hold");
        wait_out(lat);
        chk_eq("hold_latency", 64'(lat), 64'(ITER));
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0] ? 1'b0 : 1'b1;
            x_in     = 32'h3F00_0000;
            y_in     = 32'h1234_5678;
            angle_in = 32'h4000_0000;
            @(negedge clk);
            chk_eq("hold_out_valid", 64'(out_valid), 64'd1);
            chk_eq("hold_in_ready",  64'(in_ready),  64'd0);
            chk_mag("hold_mag", magnitude, sb_q[0].mag);
            chk_ang("hold_ang", angle_out, sb_q[0].ang);
        end
        in_valid = 1'b0;
        check_out("v_hold");
        out_ready = 1'b1;
        @(negedge clk);
        seen = 1'b0;
        for (int k = 0; k < ITER + 4; k++) begin
            seen = seen | out_valid | busy;
            @(negedge clk);
        end
        chk_eq("hold_no_second_vector", 64'(seen), 64'd0);

        // Back-to-back: the next vector is waiting during the DONE handshake.
        send(32'h2000_0000, 32'hE000_0000, 32'h2000_0000, 1'b1, "v_b2b_a");
        wait_out(lat);
        chk_eq("b2b_a_latency", 64'(lat), 64'(ITER));
        check_out("v_b2b_a");
        in_valid = 1'b1;
        x_in     = 32'h0C00_0000;
        y_in     = 32'h0500_0000;
        angle_in = 32'h4000_0000;
        @(negedge clk);
        chk_eq("b2b_ready_after_hs", 64'(in_ready), 64'd1);
        sb_q.push_back(model(x_in, y_in, angle_in, 1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        chk_eq("b2b_accepted", 64'(busy), 64'd1);
        $display("send v_b2b_b: x=0x%08h y=0x%08h a=0x%08h", x_in, y_in, angle_in);
        wait_out(lat);
        chk_eq("b2b_b_latency", 64'(lat), 64'(ITER));
        check_out("v_b2b_b");
        @(negedge clk);

        // Asynchronous reset at iteration 7 aborts the vector.
        send(32'h4000_0000, 32'h2000_0000, 32'h0000_0000, 1'b1, "v_abort");
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_eq("abort_out_valid", 64'(out_valid), 64'd0);
        chk_eq("abort_in_ready",  64'(in_ready),  64'd1);
        chk_eq("abort_busy",      64'(busy),      64'd0);
        chk_eq("abort_magnitude", 64'(magnitude), 64'd0);
        chk_eq("abort_angle",     64'(angle_out), 64'd0);
        sb_q.delete();
        $display("reset asserted at iteration 7, vector aborted");
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < ITER + 4; k++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk_eq("abort_no_result", 64'(seen), 64'd0);

        // A fresh vector after reset gives the correct result.
        run_vec(32'h2500_0000, 32'h1A00_0000, 32'h0000_0000, 1'b1, "v_fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
